// File: rtl/vu_frame_sequencer.sv
// Frame sequencer: tracks the per-frame maximum level and commits bar/peak heights on each vs rising edge.
// Define PEAK_HOLD_EN to build the peak-hold/decay stage; otherwise the peak marker follows the bar.
module vu_frame_sequencer #(
   parameter int LVL_W       = 9,
   parameter int MAX_LVL     = 480,
   parameter int HOLD_FRAMES = 30,
   parameter int DECAY_STEP  = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             vs,
   input  logic             smp_valid,
   input  logic [LVL_W-1:0] smp_data,
   output logic             smp_ready,
   output logic [LVL_W-1:0] bar_lvl,
   output logic [LVL_W-1:0] peak_lvl,
   output logic             cfg_valid
);

   localparam logic [1:0] ST_ACCUM   = 2'd0;
   localparam logic [1:0] ST_COMMIT  = 2'd1;
   localparam logic [1:0] ST_PUBLISH = 2'd3;
`ifdef PEAK_HOLD_EN
   localparam logic [1:0] ST_PEAK    = 2'd2;
   localparam logic [7:0] HOLD_C     = 8'(HOLD_FRAMES);
   localparam logic [LVL_W-1:0] DECAY_C = LVL_W'(DECAY_STEP);
`endif
   localparam logic [LVL_W-1:0] MAX_C = LVL_W'(MAX_LVL);

   // Out-of-range configuration stops elaboration instead of silently truncating.
   if (HOLD_FRAMES < 0 || HOLD_FRAMES > 255 || DECAY_STEP < 0 || MAX_LVL < 0 ||
       MAX_LVL >= 2**LVL_W) begin : g_bad_cfg
      $error("vu_frame_sequencer: parameter out of range");
   end

   logic [1:0]       state;
   logic [1:0]       state_nxt;
   logic             vs_d;
   logic             rise;
   logic             smp_fire;
   logic [LVL_W-1:0] acc;
`ifdef PEAK_HOLD_EN
   logic [7:0]       hold_cnt;
`endif

   function automatic logic [LVL_W-1:0] sat_lvl(input logic [LVL_W-1:0] v);
      return (v > MAX_C) ? MAX_C : v;
   endfunction

   function automatic logic [LVL_W-1:0] max_lvl(input logic [LVL_W-1:0] a,
                                                 input logic [LVL_W-1:0] b);
      return (a > b) ? a : b;
   endfunction

`ifdef PEAK_HOLD_EN
   // Decay clamps at zero before flooring at the current bar height.
   function automatic logic [LVL_W-1:0] decay_lvl(input logic [LVL_W-1:0] pk,
                                                   input logic [LVL_W-1:0] bar);
      logic [LVL_W-1:0] dropped;
      dropped = (pk > DECAY_C) ? (pk - DECAY_C) : '0;
      return max_lvl(dropped, bar);
   endfunction
`endif

   assign rise     = vs & ~vs_d;
   assign smp_fire = smp_valid & smp_ready;

   always_comb begin
      state_nxt = state;
      case (state)
         ST_ACCUM:   if (rise) state_nxt = ST_COMMIT;
`ifdef PEAK_HOLD_EN
         ST_COMMIT:  state_nxt = ST_PEAK;
         ST_PEAK:    state_nxt = ST_PUBLISH;
`else
         ST_COMMIT:  state_nxt = ST_PUBLISH;
`endif
         ST_PUBLISH: state_nxt = ST_ACCUM;
         default:    state_nxt = ST_ACCUM;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= ST_ACCUM;
         vs_d      <= 1'b1;
         acc       <= '0;
         bar_lvl   <= '0;
         peak_lvl  <= '0;
         smp_ready <= 1'b0;
         cfg_valid <= 1'b0;
`ifdef PEAK_HOLD_EN
         hold_cnt  <= '0;
`endif
      end else begin
         vs_d      <= vs;
         state     <= state_nxt;
         smp_ready <= (state_nxt == ST_ACCUM);
         cfg_valid <= (state_nxt == ST_PUBLISH);
         case (state)
            // A sample accepted in the rise cycle still belongs to the closing frame.
            ST_ACCUM: begin
               if (smp_fire) acc <= max_lvl(acc, sat_lvl(smp_data));
            end
            ST_COMMIT: begin
               bar_lvl <= acc;
               acc     <= '0;
`ifndef PEAK_HOLD_EN
               peak_lvl <= acc;
`endif
            end
`ifdef PEAK_HOLD_EN
            ST_PEAK: begin
               if (bar_lvl >= peak_lvl) begin
                  peak_lvl <= bar_lvl;
                  hold_cnt <= HOLD_C;
               end else if (hold_cnt != 8'd0) begin
                  hold_cnt <= hold_cnt - 8'd1;
               end else begin
                  peak_lvl <= decay_lvl(peak_lvl, bar_lvl);
               end
            end
`endif
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_vu_frame_sequencer.sv
// Scoreboard bench for vu_frame_sequencer: frame-level reference model, directed cases plus random frames.
module tb_vu_frame_sequencer;
   localparam int LVL_W   = 9;
   localparam int MAX_LVL = 480;
   localparam int HF      = 2;
   localparam int DS      = 4;
`ifdef PEAK_HOLD_EN
   localparam int LAT = 3;
`else
   localparam int LAT = 2;
`endif

   logic             clk = 1'b0;
   logic             rst = 1'b1;
   logic             vs = 1'b1;
   logic             smp_valid = 1'b0;
   logic [LVL_W-1:0] smp_data = '0;
   logic             smp_ready;
   logic [LVL_W-1:0] bar_lvl;
   logic [LVL_W-1:0] peak_lvl;
   logic             cfg_valid;

   int n_tests = 0;
   int n_fail  = 0;
   int cyc     = 0;

   typedef struct {
      int bar;
      int peak;
      int due;
   } exp_t;
   exp_t sb[$];

   // Reference model state, kept at frame level.
   int   m_blk  = 0;
   int   m_fmax = 0;
   int   m_peak = 0;
   int   m_hold = 0;
   logic m_vsp  = 1'b1;
   logic m_rstq = 1'b1;

   vu_frame_sequencer #(
      .LVL_W(LVL_W), .MAX_LVL(MAX_LVL), .HOLD_FRAMES(HF), .DECAY_STEP(DS)
   ) dut (
      .clk(clk), .rst(rst), .vs(vs), .smp_valid(smp_valid), .smp_data(smp_data),
      .smp_ready(smp_ready), .bar_lvl(bar_lvl), .peak_lvl(peak_lvl), .cfg_valid(cfg_valid)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Frame commit as the reference sees it: bar = frame max, then peak hold/decay.
   task automatic model_commit();
      exp_t e;
      int   b;
      b = m_fmax;
`ifdef PEAK_HOLD_EN
      if (b >= m_peak) begin
         m_peak = b;
         m_hold = HF;
      end else if (m_hold > 0) begin
         m_hold--;
      end else begin
         m_peak = (m_peak - DS > b) ? (m_peak - DS) : b;
      end
`else
      m_peak = b;
`endif
      e.bar  = b;
      e.peak = m_peak;
      e.due  = cyc + LAT;
      sb.push_back(e);
      m_fmax = 0;
      m_blk  = LAT;
   endtask

   task automatic step(input logic v, input logic sv, input logic [LVL_W-1:0] sd,
                       input logic r, output logic acc);
      logic rdy_e;
      int   s;
      vs        = v;
      smp_valid = sv;
      smp_data  = sd;
      rst       = r;
      rdy_e     = !m_rstq && (m_blk == 0);
      #1 chk("smp_ready", 32'(smp_ready), 32'(rdy_e));
      acc = 1'b0;
      @(negedge clk);
      #1;
      if (r) begin
         m_blk = 0; m_vsp = 1'b1; m_fmax = 0; m_peak = 0; m_hold = 0;
         sb.delete();
      end else begin
         if (sv && rdy_e) begin
            acc = 1'b1;
            s = (int'(sd) > MAX_LVL) ? MAX_LVL : int'(sd);
            if (s > m_fmax) m_fmax = s;
         end
         if (v && !m_vsp && m_blk == 0) model_commit();
         else if (m_blk > 0) m_blk--;
         m_vsp = v;
      end
      m_rstq = r;
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n, input logic v);
      logic a;
      for (int i = 0; i < n; i++) step(v, 1'b0, '0, 1'b0, a);
   endtask

   task automatic send(input logic v, input logic [LVL_W-1:0] d);
      logic a;
      a = 1'b0;
      for (int i = 0; i < 8 && !a; i++) step(v, 1'b1, d, 1'b0, a);
      if (!a) chk("send_accept", 0, 1);
   endtask

   task automatic rise(input logic sv, input logic [LVL_W-1:0] d);
      logic a;
      step(1'b1, sv, d, 1'b0, a);
   endtask

   task automatic frame_end();
      rise(1'b0, '0);
      idle(LAT + 3, 1'b1);
      idle(2, 1'b0);
   endtask

   task automatic do_reset(input int n);
      logic a;
      for (int i = 0; i < n; i++) step(1'b1, 1'b0, '0, 1'b1, a);
   endtask

   task automatic chk_zero();
      chk("rst_bar_lvl", 32'(bar_lvl), 0);
      chk("rst_peak_lvl", 32'(peak_lvl), 0);
      chk("rst_cfg_valid", 32'(cfg_valid), 0);
   endtask

   // Monitor: every cfg_valid pulse must match the oldest pending commit, on time.
   always @(negedge clk) begin
      exp_t e;
      if (sb.size() > 0 && sb[0].due < cyc) begin
         chk("cfg_missing", 0, 1);
         void'(sb.pop_front());
      end
      if (cfg_valid !== 1'b0) begin
         if (sb.size() == 0) begin
            chk("cfg_unexpected", 32'(cfg_valid), 0);
         end else begin
            e = sb.pop_front();
            chk("cfg_time", cyc, e.due);
            chk("bar_lvl", 32'(bar_lvl), e.bar);
            chk("peak_lvl", 32'(peak_lvl), e.peak);
         end
      end
   end

   initial begin
      logic             a;
      logic             pv;
      logic [LVL_W-1:0] pd;
      int               lo;
      int               hi;
      @(posedge clk);
      #1;
      // Reset with vs held high: release must not look like a rising edge.
      do_reset(3);
      chk_zero();
      idle(6, 1'b1);
      idle(2, 1'b0);
      frame_end();
      // Basic max tracking, saturation, and the rise-cycle sample.
      send(1'b0, 9'd100); send(1'b0, 9'd350); send(1'b0, 9'd200);
      frame_end();
      send(1'b0, 9'd511);
      frame_end();
      send(1'b0, 9'd50);
      rise(1'b1, 9'd300);
      idle(LAT + 3, 1'b1);
      idle(2, 1'b0);
      frame_end();
      // Reset in the cycle before the pulse would have been published.
      send(1'b0, 9'd200);
      rise(1'b0, '0);
      idle(LAT - 2, 1'b1);
      step(1'b1, 1'b0, '0, 1'b1, a);
      chk_zero();
      send(1'b0, 9'd123);
      frame_end();
      // Hold then decay floored at bar.
      do_reset(2);
      send(1'b0, 9'd100);
      frame_end();
      for (int i = 0; i < 6; i++) begin
         send(1'b0, 9'd90);
         frame_end();
      end
      // Decay must not wrap below zero.
      do_reset(2);
      send(1'b0, 9'd6);
      frame_end();
      for (int i = 0; i < 5; i++) frame_end();
      // Valid held across a rise: sample waits out the blocked cycles.
      idle(2, 1'b0);
      rise(1'b1, 9'd40);
      send(1'b1, 9'd77);
      idle(LAT + 1, 1'b1);
      idle(2, 1'b0);
      frame_end();
      // Random frames with random sample traffic obeying the handshake.
      pv = 1'b0;
      pd = '0;
      for (int f = 0; f < 40; f++) begin
         lo = $urandom_range(1, 20);
         hi = $urandom_range(1, 12);
         for (int c = 0; c < lo + hi; c++) begin
            if (!pv) begin
               pv = ($urandom % 3) != 0;
               pd = LVL_W'($urandom % 512);
            end
            step(c >= lo, pv, pd, 1'b0, a);
            if (a) pv = 1'b0;
         end
      end
      idle(LAT + 3, 1'b0);
      chk("sb_drain", sb.size(), 0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1, "watchdog expired");
   end

endmodule

// File: doc/vu_frame_sequencer.md
Name: vu_frame_sequencer

Overview:
- Controller between the audio level path and the VGA bar renderer.
- Accepts a stream of level samples through a valid/ready handshake and tracks the per-frame maximum.
- On each vertical sync rising edge, commits the maximum as the bar height and updates a peak-hold marker with hold and decay.
- Publishes both values to the renderer with a one-cycle strobe, so the renderer only changes the picture between frames.

Parameters:
- LVL_W, 9, width of level values in display lines.
- MAX_LVL, 480, saturation ceiling for levels (active display height).
- HOLD_FRAMES, 30, frames the peak marker is held before decay starts; counter width is 8 bits, legal range 0..255.
- DECAY_STEP, 4, lines the peak marker drops per frame once the hold expires.

Ports:
- clk  in  1  system clock (pixel clock domain of the timing generator).
- rst  in  1  reset; one clock domain, synchronous, active-high.
- vs  in  1  vertical sync from the timing generator, active-high, synchronous to clk.
- smp_valid  in  1  level sample valid.
- smp_data  in  LVL_W  level sample in lines.
- smp_ready  out  1  sequencer can accept a sample.
- bar_lvl  out  LVL_W  committed bar height.
- peak_lvl  out  LVL_W  committed peak marker height.
- cfg_valid  out  1  one-cycle strobe: bar_lvl/peak_lvl updated.

Behaviour:
- Reset (rst=1 at a clock edge), all registers:
  - bar_lvl=0, peak_lvl=0, acc=0, hold_cnt=0, cfg_valid=0, state=ACCUM.
  - vs_d=1, so vs high at reset release is not a rising edge.
  - smp_ready=0 while rst=1; smp_ready=1 from the first cycle after release.
  - Reset mid-sequence aborts the sequence with no cfg_valid pulse.
- Edge detect: rise = vs & ~vs_d; vs_d <= vs every cycle.
- Saturation: sat = (smp_data > MAX_LVL) ? MAX_LVL : smp_data.
- ACCUM:
  - smp_ready=1.
  - On smp_valid & smp_ready: acc <= max(acc, sat).
  - On rise (edge N): state <= COMMIT.
  - A sample accepted in the rise cycle belongs to the closing frame.
- COMMIT:
  - smp_ready=0; bar_lvl <= acc; acc <= 0; state <= PEAK.
- PEAK (uses the new bar_lvl):
  - If bar_lvl >= peak_lvl: peak_lvl <= bar_lvl; hold_cnt <= HOLD_FRAMES.
  - Else if hold_cnt != 0: hold_cnt <= hold_cnt-1, peak_lvl unchanged.
  - Else: peak_lvl <= max(peak_lvl - DECAY_STEP, bar_lvl). The subtraction must not wrap below 0.
  - state <= PUBLISH.
- PUBLISH:
  - cfg_valid=1 for exactly this cycle; smp_ready=0; state <= ACCUM.
- Latency:
  - Rise at edge N; bar_lvl valid after N+1; peak_lvl valid after N+2.
  - cfg_valid high between N+2 and N+3.
  - smp_ready low for cycles N+1..N+3; samples presented then are held off by the handshake, not dropped.
- Outputs bar_lvl/peak_lvl are stable between cfg_valid pulses.
- A frame with no accepted samples commits bar_lvl=0.
- A rise while not in ACCUM is ignored; it cannot occur at VGA frame rates.
- Outputs are registered.

Optional Feature:
- Macro PEAK_HOLD_EN.
- Defined: the PEAK state and hold/decay logic exist as above.
- Undefined:
  - No PEAK state and no hold_cnt.
  - COMMIT also sets peak_lvl <= acc.
  - COMMIT goes directly to PUBLISH, so cfg_valid is high between N+1 and N+2.
  - smp_ready is low for 2 cycles.
  - peak_lvl always equals bar_lvl.

Test Plan:
- Reset release with vs held high, no samples:
  - No cfg_valid until vs falls and rises again.
  - Then bar_lvl=0, peak_lvl=0, one cfg_valid pulse 3 cycles after the rise (2 without PEAK_HOLD_EN).
- Samples 100, 350, 200 in a frame, then vs rise:
  - bar_lvl=350, peak_lvl=350, hold_cnt=30, single cfg_valid pulse.
- Sample 511 (> MAX_LVL):
  - Committed bar_lvl=480.
  - Sample 300 accepted in the same cycle as the rise is counted in the closing frame.
- HOLD_FRAMES=2, DECAY_STEP=4; frame 1 level 100, then frames of level 90:
  - peak_lvl 100, 100, 100, 96, 92, 90, 90 (floored at bar_lvl).
  - With level 0 from a peak of 6: 6, then 2, then 0, no wrap.
- smp_valid held high across a vs rise:
  - smp_ready low for exactly 3 cycles (2 without the macro).
  - The pending sample is accepted on the first ACCUM cycle into the new frame's acc.
- rst asserted in the PEAK cycle:
  - No cfg_valid, all outputs 0.
  - Normal accumulation resumes the cycle after release.
